// File: rtl/mc_proc_core.sv
// mc_proc_core: multi-cycle processor controller with a 16-entry register file,
// 16-word data memory and add/compare datapath.
// Optional feature: define MCP_SUB_OP_EN to make opcode 011 a subtract
// (otherwise 011 is a NOP that still pulses done).
module mc_proc_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              step_req,
  input  logic              exec_req,
  input  logic [15:0]       ext_instr,
  input  logic              view_dec,
  input  logic              view_inc,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [3:0]        view_addr,
  output logic [DATA_W-1:0] view_data,
  output logic              busy,
  output logic              halted,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [2:0] OP_MEM  = 3'b000;
  localparam logic [2:0] OP_REG  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t            state, next_state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] dmem [16];
  logic              busy_d, halted_d, done_d;

  logic [2:0]        op;
  logic [DATA_W-1:0] imm, rd_a, rd_b, sum;

  assign op        = ir[15:13];
  assign imm       = DATA_W'(ir[7:0]);
  assign rd_a      = regs[ir[7:4]];
  assign rd_b      = regs[ir[3:0]];
  assign sum       = rd_a + rd_b;
  assign imem_addr = pc;
  assign view_data = dmem[view_addr];

`ifdef MCP_SUB_OP_EN
  logic [DATA_W-1:0] diff;
  assign diff = rd_a - rd_b;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; IDLE honours one request per cycle by priority
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (restart)       next_state = IDLE;
        else if (step_req) next_state = FETCH;
        else if (exec_req) next_state = EXEC;
      end
      FETCH: next_state = EXEC;
      EXEC:  next_state = (op == OP_HALT) ? HALT : IDLE;
      HALT:  if (restart) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, registered below so flags line up with the new state
  always_comb begin
    busy_d   = (next_state == FETCH) || (next_state == EXEC);
    halted_d = (next_state == HALT);
    done_d   = (state == EXEC) && (op != OP_HALT);
  end

  // Status output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      halted <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy   <= busy_d;
      halted <= halted_d;
      done   <= done_d;
    end
  end

  // Control registers: pc, instruction register, view pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      view_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (restart) begin
            pc        <= '0;
            view_addr <= '0;
          end else if (step_req) begin
            pc <= pc;
          end else if (exec_req) begin
            ir <= ext_instr;
          end else if (view_dec) begin
            view_addr <= view_addr - 4'd1;
          end else if (view_inc) begin
            view_addr <= view_addr + 4'd1;
          end
        end
        FETCH: begin
          ir <= imem_data;
          pc <= pc + PC_W'(1);
        end
        EXEC: begin
          if (op == OP_BEQ && rd_a == rd_b) pc <= PC_W'(ir[12:8]);
        end
        HALT: begin
          if (restart) begin
            pc        <= '0;
            view_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file and data memory commit at the closing edge of EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
        dmem[i] <= '0;
      end
    end else if (state == EXEC) begin
      case (op)
        OP_MEM: begin
          if (ir[12]) dmem[ir[11:8]] <= imm;
          else        dmem[ir[7:4]]  <= rd_b;
        end
        OP_REG: begin
          if (ir[12]) regs[ir[11:8]] <= imm;
          else        regs[ir[7:4]]  <= dmem[ir[3:0]];
        end
        OP_ADD: regs[ir[11:8]] <= sum;
`ifdef MCP_SUB_OP_EN
        OP_SUB: regs[ir[11:8]] <= diff;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_proc_core.sv
// Self-checking bench for mc_proc_core (DATA_W=8, PC_W=5) with a reference
// model and a queue of expected pc values popped on each done pulse.
module tb_mc_proc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0, step_req = 1'b0, exec_req = 1'b0;
  logic        view_dec = 1'b0, view_inc = 1'b0;
  logic [15:0] ext_instr = '0;
  logic [4:0]  imem_addr;
  logic [15:0] imem_data;
  logic [3:0]  view_addr;
  logic [7:0]  view_data;
  logic        busy, halted, done;

  logic [15:0] rom [32];
  assign imem_data = rom[imem_addr];

  mc_proc_core #(.DATA_W(8), .PC_W(5)) dut (
    .clk(clk), .reset(reset), .restart(restart), .step_req(step_req),
    .exec_req(exec_req), .ext_instr(ext_instr), .view_dec(view_dec),
    .view_inc(view_inc), .imem_addr(imem_addr), .imem_data(imem_data),
    .view_addr(view_addr), .view_data(view_data), .busy(busy),
    .halted(halted), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [4:0] exp_q [$];

  logic [7:0] m_r [16];
  logic [7:0] m_d [16];
  logic [4:0] m_pc;
  logic [3:0] m_view;

  // Scoreboard: each done pulse must match the oldest expected pc
  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected: done=1 with empty scoreboard, pc=%0d", imem_addr);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if (imem_addr !== e) begin
          failures++;
          $display("FAIL done_pc: got %0d expected %0d", imem_addr, e);
        end
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_r[i] = '0;
      m_d[i] = '0;
    end
    m_pc = '0;
    m_view = '0;
  endfunction

  // Reference execution of one instruction; returns 1 for halt
  function automatic bit model_exec(input logic [15:0] ins);
    logic [7:0] a, b;
    a = m_r[ins[7:4]];
    b = m_r[ins[3:0]];
    case (ins[15:13])
      3'b000: if (ins[12]) m_d[ins[11:8]] = ins[7:0]; else m_d[ins[7:4]] = b;
      3'b001: if (ins[12]) m_r[ins[11:8]] = ins[7:0]; else m_r[ins[7:4]] = m_d[ins[3:0]];
      3'b010: m_r[ins[11:8]] = a + b;
`ifdef MCP_SUB_OP_EN
      3'b011: m_r[ins[11:8]] = a - b;
`endif
      3'b101: if (a == b) m_pc = ins[12:8];
      3'b111: return 1'b1;
      default: ;
    endcase
    return 1'b0;
  endfunction

  task automatic pulse(input int sel);
    @(posedge clk); #1;
    case (sel)
      0: restart = 1'b1;
      1: step_req = 1'b1;
      2: exec_req = 1'b1;
      3: view_dec = 1'b1;
      default: view_inc = 1'b1;
    endcase
    @(posedge clk); #1;
    restart = 1'b0; step_req = 1'b0; exec_req = 1'b0;
    view_dec = 1'b0; view_inc = 1'b0;
  endtask

  // Issue a step (is_step=1) or external instruction, expecting done after 3 or 2 cycles
  task automatic issue(input bit is_step, input logic [15:0] ins_ext);
    logic [15:0] ins;
    bit h;
    int n;
    int lat;
    if (is_step) begin
      ins = rom[m_pc];
      m_pc = m_pc + 5'd1;
    end else begin
      ins = ins_ext;
      ext_instr = ins_ext;
    end
    h = model_exec(ins);
    if (!h) exp_q.push_back(m_pc);
    pulse(is_step ? 1 : 2);
    lat = is_step ? 3 : 2;
    n = 1;
    while (n <= 5) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    checks++;
    if (h) begin
      if (n <= 5) begin
        failures++;
        $display("FAIL halt_no_done: done seen at cycle %0d, expected none", n);
      end
    end else if (n != lat) begin
      failures++;
      $display("FAIL done_latency: instr %h got cycle %0d expected %0d", ins, n, lat);
    end
  endtask

  task automatic move_view(input logic [3:0] tgt);
    while (m_view != tgt) begin
      pulse(4);
      m_view = m_view + 4'd1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({imem_addr, view_addr, view_data, busy, halted, done} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state: pc=%0d view=%0d data=%h busy=%b halted=%b done=%b expected all zero",
               imem_addr, view_addr, view_data, busy, halted, done);
    end
  endtask

  task automatic test_program();
    int d0;
    rom[0] = 16'h3105; rom[1] = 16'h3203; rom[2] = 16'h4312;
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) issue(1'b1, 16'h0);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 3) begin
      failures++;
      $display("FAIL program_done_count: got %0d expected 3", done_cnt - d0);
    end
    checks++;
    if (imem_addr !== 5'd3) begin
      failures++;
      $display("FAIL program_pc: got %0d expected 3", imem_addr);
    end
    issue(1'b0, 16'h0033);
    move_view(4'd3);
    @(negedge clk);
    checks++;
    if (view_data !== 8'h08 || view_data !== m_d[3]) begin
      failures++;
      $display("FAIL program_r3: got %h expected 08 (model %h)", view_data, m_d[3]);
    end
  endtask

  task automatic test_exec_view();
    pulse(0);
    m_pc = '0; m_view = '0;
    issue(1'b0, 16'h1A7F);
    for (int i = 0; i < 10; i++) begin
      pulse(4);
      m_view = m_view + 4'd1;
    end
    @(negedge clk);
    checks++;
    if (view_addr !== 4'hA || view_data !== 8'h7F || imem_addr !== 5'd0) begin
      failures++;
      $display("FAIL exec_view: view=%h data=%h pc=%0d expected A 7F 0", view_addr, view_data, imem_addr);
    end
  endtask

  task automatic test_branch();
    logic [4:0] k;
    issue(1'b0, 16'h3105);
    issue(1'b0, 16'h3205);
    rom[m_pc] = 16'hB712;
    issue(1'b1, 16'h0);
    @(negedge clk);
    checks++;
    if (imem_addr !== 5'd23 || imem_addr !== m_pc) begin
      failures++;
      $display("FAIL branch_taken: pc=%0d expected 23", imem_addr);
    end
    issue(1'b0, 16'h3206);
    k = m_pc;
    rom[k] = 16'hB712;
    issue(1'b1, 16'h0);
    @(negedge clk);
    checks++;
    if (imem_addr !== k + 5'd1) begin
      failures++;
      $display("FAIL branch_not_taken: pc=%0d expected %0d", imem_addr, k + 5'd1);
    end
  endtask

  task automatic test_add_wrap();
    issue(1'b0, 16'h31FF);
    issue(1'b0, 16'h3202);
    issue(1'b0, 16'h4312);
    issue(1'b0, 16'h0033);
    move_view(4'd3);
    @(negedge clk);
    checks++;
    if (view_data !== 8'h01) begin
      failures++;
      $display("FAIL add_carry: got %h expected 01", view_data);
    end
    issue(1'b0, 16'h4111);
    issue(1'b0, 16'h0051);
    move_view(4'd5);
    @(negedge clk);
    checks++;
    if (view_data !== 8'hFE || view_data !== m_d[5]) begin
      failures++;
      $display("FAIL add_self: got %h expected FE", view_data);
    end
    pulse(0);
    m_pc = '0; m_view = '0;
    pulse(3);
    m_view = 4'hF;
    @(negedge clk);
    checks++;
    if (view_addr !== 4'hF || view_data !== m_d[15]) begin
      failures++;
      $display("FAIL view_wrap: view=%h data=%h expected F %h", view_addr, view_data, m_d[15]);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    rom[m_pc] = 16'h0000;
    m_pc = m_pc + 5'd1;
    exp_q.push_back(m_pc);
    d0 = done_cnt;
    @(posedge clk); #1;
    step_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step_req = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || imem_addr !== m_pc) begin
      failures++;
      $display("FAIL busy_ignore: dones=%0d pc=%0d expected 1 %0d", done_cnt - d0, imem_addr, m_pc);
    end
  endtask

  task automatic test_pc_wrap();
    issue(1'b0, 16'hBF00);
    rom[31] = 16'h0000;
    issue(1'b1, 16'h0);
    @(negedge clk);
    checks++;
    if (imem_addr !== 5'd0) begin
      failures++;
      $display("FAIL pc_wrap: pc=%0d expected 0", imem_addr);
    end
  endtask

  task automatic test_sub();
    logic [7:0] exp_r3;
`ifdef MCP_SUB_OP_EN
    exp_r3 = 8'hFD;
`else
    exp_r3 = 8'h00;
`endif
    issue(1'b0, 16'h3102);
    issue(1'b0, 16'h3205);
    issue(1'b0, 16'h3300);
    issue(1'b0, 16'h6312);
    issue(1'b0, 16'h0033);
    move_view(4'd3);
    @(negedge clk);
    checks++;
    if (view_data !== exp_r3 || view_data !== m_d[3]) begin
      failures++;
      $display("FAIL sub_op: got %h expected %h", view_data, exp_r3);
    end
  endtask

  task automatic test_halt();
    int d0;
    logic [4:0] hp;
    rom[m_pc] = 16'hE000;
    issue(1'b1, 16'h0);
    hp = m_pc;
    d0 = done_cnt;
    @(negedge clk);
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL halt_state: halted=%b busy=%b expected 1 0", halted, busy);
    end
    pulse(1);
    ext_instr = 16'h1A55;
    pulse(2);
    for (int i = 0; i < 4; i++) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || imem_addr !== hp || done_cnt != d0 || view_data !== m_d[m_view]) begin
      failures++;
      $display("FAIL halt_ignore: halted=%b pc=%0d dones=%0d expected 1 %0d 0",
               halted, imem_addr, done_cnt - d0, hp);
    end
    pulse(0);
    m_pc = '0; m_view = '0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (halted !== 1'b0 || busy !== 1'b0 || imem_addr !== 5'd0 || view_addr !== 4'd0 || done_cnt != d0) begin
      failures++;
      $display("FAIL halt_restart: halted=%b busy=%b pc=%0d view=%0d dones=%0d expected 0 0 0 0 0",
               halted, busy, imem_addr, view_addr, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    rom[m_pc] = 16'h1955;
    @(posedge clk); #1;
    step_req = 1'b1;
    @(posedge clk); #1;
    step_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || imem_addr !== 5'd0 || view_addr !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_state: busy=%b done=%b pc=%0d view=%0d expected zeros",
               busy, done, imem_addr, view_addr);
    end
    move_view(4'd9);
    @(negedge clk);
    checks++;
    if (view_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_write: dmem[9]=%h expected 00", view_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_program();
    test_exec_view();
    test_branch();
    test_add_wrap();
    test_back_to_back();
    test_pc_wrap();
    test_sub();
    test_halt();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected done pulses never seen", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
